// File: rtl/caliptra_apb_init_pkg.sv
// Shared types for the Caliptra APB initiator: bus widths, queued command,
// FSM state encoding and the held response.
package caliptra_apb_init_pkg;

  localparam int CALIPTRA_APB_ADDR_WIDTH = 32;
  localparam int CALIPTRA_APB_DATA_WIDTH = 32;
  localparam int CALIPTRA_APB_USER_WIDTH = 32;

  typedef struct packed {
    logic                               write;
    logic [CALIPTRA_APB_ADDR_WIDTH-1:0] addr;
    logic [CALIPTRA_APB_DATA_WIDTH-1:0] wdata;
    logic [CALIPTRA_APB_USER_WIDTH-1:0] user;
  } apb_cmd_t;

  localparam int APB_CMD_W = $bits(apb_cmd_t);

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [CALIPTRA_APB_DATA_WIDTH-1:0] rdata;
    logic                               err;
    logic                               timeout;
  } apb_rsp_t;

endpackage

// File: rtl/caliptra_apb_init_fifo.sv
// In-order command buffer for the APB initiator. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
module caliptra_apb_init_fifo
  import caliptra_apb_init_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [APB_CMD_W-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [APB_CMD_W-1:0] pop_data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]          wr_ptr_q, wr_ptr_d;
  logic [PW:0]          rd_ptr_q, rd_ptr_d;
  logic [APB_CMD_W-1:0] mem_q [DEPTH];
  logic                 do_push, do_pop;

  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, do_pop};

  // NOTE: state registers use <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and resetting an array forces flops instead of RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/caliptra_apb_initiator.sv
// Queued APB initiator: commands are buffered, issued as SETUP/ACCESS pairs and
// answered through a single response slot. Optional ACCESS timeout: CALIPTRA_APB_INIT_TIMEOUT_EN.
module caliptra_apb_initiator
  import caliptra_apb_init_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                               core_clk,
  input  logic                               cptra_rst_b,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_write,
  input  logic [CALIPTRA_APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CALIPTRA_APB_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [CALIPTRA_APB_USER_WIDTH-1:0] cmd_user,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [CALIPTRA_APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                               rsp_err,
  output logic                               rsp_timeout,
  output logic                               psel,
  output logic                               penable,
  output logic                               pwrite,
  output logic [CALIPTRA_APB_ADDR_WIDTH-1:0] paddr,
  output logic [CALIPTRA_APB_DATA_WIDTH-1:0] pwdata,
  output logic [CALIPTRA_APB_USER_WIDTH-1:0] pauser,
  input  logic [CALIPTRA_APB_DATA_WIDTH-1:0] prdata,
  input  logic                               pready,
  input  logic                               pslverr
);

  apb_state_e           state_q, state_d;
  apb_cmd_t             push_cmd, head;
  logic [APB_CMD_W-1:0] head_raw;
  logic                 fifo_full, fifo_empty, push, access_done, tmo_hit;
  logic                 rsp_valid_q, rsp_valid_d;
  apb_rsp_t             rsp_q, rsp_d;

  assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, user: cmd_user};
  assign head      = apb_cmd_t'(head_raw);
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;

  caliptra_apb_init_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (core_clk),
    .rst_ni      (cptra_rst_b),
    .push_i      (push),
    .push_data_i (push_cmd),
    .pop_i       (access_done),
    .pop_data_o  (head_raw),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter holds the number of ACCESS cycles already completed.
  assign tmo_cnt_d = (state_q == APB_ACCESS) ? tmo_cnt_q + CNT_W'(1) : '0;
  assign tmo_hit   = (state_q == APB_ACCESS) && !pready &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge core_clk) begin
    if (!cptra_rst_b) tmo_cnt_q <= '0;
    else              tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign access_done = (state_q == APB_ACCESS) && (pready || tmo_hit);

  always_ff @(posedge core_clk) begin
    if (!cptra_rst_b) state_q <= APB_IDLE;
    else              state_q <= state_d;
  end

  // A command pushed this cycle is already visible at the head next cycle,
  // which allows SETUP to follow acceptance immediately.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      APB_IDLE:   if ((!fifo_empty || push) && !rsp_valid_q) state_d = APB_SETUP;
      APB_SETUP:  state_d = APB_ACCESS;
      APB_ACCESS: if (access_done) state_d = APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pauser  = '0;
    if (state_q != APB_IDLE) begin
      psel    = 1'b1;
      penable = (state_q == APB_ACCESS);
      pwrite  = head.write;
      paddr   = head.addr;
      pwdata  = head.wdata;
      pauser  = head.user;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
    if (access_done) begin
      rsp_valid_d = 1'b1;
      if (pready) begin
        rsp_d.rdata   = (!head.write && !pslverr) ? prdata : '0;
        rsp_d.err     = pslverr;
        rsp_d.timeout = 1'b0;
      end else begin
        rsp_d.rdata   = '0;
        rsp_d.err     = 1'b1;
        rsp_d.timeout = 1'b1;
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (!cptra_rst_b) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_caliptra_apb_initiator.sv
// Directed bench for caliptra_apb_initiator: table of single transfers plus
// hand sequences for FIFO full, timeout and mid-transfer reset.
module tb_caliptra_apb_initiator;
  import caliptra_apb_init_pkg::*;

  logic        core_clk = 1'b0;
  logic        cptra_rst_b;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata, cmd_user;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, pauser, prdata;

  int checks = 0;
  int failures = 0;

  always #5 core_clk = ~core_clk;

  caliptra_apb_initiator #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .core_clk    (core_clk),
    .cptra_rst_b (cptra_rst_b),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_user    (cmd_user),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pauser      (pauser),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] user;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } xfer_vec_t;

  xfer_vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] u);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_user  = u;
  endtask

  task automatic clear_cmd();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_user  = '0;
  endtask

  task automatic run_vec(input int idx, input xfer_vec_t v);
    string t;
    t = $sformatf("vec%0d", idx);
    drive_cmd(v.write, v.addr, v.wdata, v.user);
    check({t, " N cmd_ready"}, cmd_ready, 1);
    check({t, " N psel"}, psel, 0);
    step();
    clear_cmd();
    check({t, " setup psel"}, psel, 1);
    check({t, " setup penable"}, penable, 0);
    check({t, " setup paddr"}, paddr, v.addr);
    check({t, " setup pwrite"}, pwrite, v.write);
    check({t, " setup pwdata"}, pwdata, v.wdata);
    check({t, " setup pauser"}, pauser, v.user);
    step();
    for (int i = 0; i <= v.waits; i++) begin
      pready  = (i == v.waits);
      pslverr = (i == v.waits) ? v.slverr : 1'b0;
      prdata  = (i == v.waits) ? v.prdata : 32'hBAD0_0000 + 32'(i);
      check({t, " access psel"}, psel, 1);
      check({t, " access penable"}, penable, 1);
      check({t, " access paddr"}, paddr, v.addr);
      check({t, " access pwdata"}, pwdata, v.wdata);
      step();
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    check({t, " rsp psel"}, psel, 0);
    check({t, " rsp_valid"}, rsp_valid, 1);
    check({t, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({t, " rsp_err"}, rsp_err, v.exp_err);
    check({t, " rsp_timeout"}, rsp_timeout, 0);
    for (int h = 0; h < v.hold; h++) begin
      step();
      check({t, " hold rsp_valid"}, rsp_valid, 1);
      check({t, " hold rsp_rdata"}, rsp_rdata, v.exp_rdata);
      check({t, " hold psel"}, psel, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({t, " rsp consumed"}, rsp_valid, 0);
  endtask

  task automatic serve_one(input logic [31:0] exp_addr, input logic [31:0] rd);
    int n;
    n = 0;
    while (!(psel && penable) && n < 20) begin
      step();
      n++;
    end
    check("serve reached ACCESS", psel && penable, 1);
    check("serve paddr order", paddr, exp_addr);
    pready = 1'b1;
    prdata = rd;
    step();
    pready = 1'b0;
    prdata = '0;
    check("serve rsp_valid", rsp_valid, 1);
    check("serve rsp_rdata", rsp_rdata, rd);
    check("serve rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{write: 1'b1, addr: 32'h3003_0000, wdata: 32'hDEAD_BEEF, user: 32'hFFFF_FFFF,
                waits: 0, slverr: 1'b0, prdata: 32'h5555_AAAA, hold: 0,
                exp_rdata: 32'h0, exp_err: 1'b0};
    vecs[1] = '{write: 1'b0, addr: 32'h3003_0010, wdata: 32'h0, user: 32'h0000_0001,
                waits: 3, slverr: 1'b0, prdata: 32'h1234_5678, hold: 2,
                exp_rdata: 32'h1234_5678, exp_err: 1'b0};
    vecs[2] = '{write: 1'b0, addr: 32'h3003_0020, wdata: 32'h0, user: 32'h0000_0002,
                waits: 0, slverr: 1'b1, prdata: 32'hFFFF_FFFF, hold: 0,
                exp_rdata: 32'h0, exp_err: 1'b1};
    vecs[3] = '{write: 1'b1, addr: 32'h3003_0030, wdata: 32'h0BAD_F00D, user: 32'h0000_0003,
                waits: 1, slverr: 1'b1, prdata: 32'h7777_7777, hold: 1,
                exp_rdata: 32'h0, exp_err: 1'b1};
    vecs[4] = '{write: 1'b0, addr: 32'h3003_0040, wdata: 32'h0, user: 32'hA5A5_A5A5,
                waits: 0, slverr: 1'b0, prdata: 32'hA5A5_0F0F, hold: 0,
                exp_rdata: 32'hA5A5_0F0F, exp_err: 1'b0};

    cptra_rst_b = 1'b0;
    rsp_ready   = 1'b0;
    pready      = 1'b0;
    pslverr     = 1'b0;
    prdata      = '0;
    clear_cmd();
    step();
    step();
    check("reset cmd_ready", cmd_ready, 1);
    check("reset psel", psel, 0);
    check("reset penable", penable, 0);
    check("reset pwrite", pwrite, 0);
    check("reset paddr", paddr, 0);
    check("reset pwdata", pwdata, 0);
    check("reset pauser", pauser, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    check("reset rsp_err", rsp_err, 0);
    check("reset rsp_timeout", rsp_timeout, 0);
    cptra_rst_b = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // FIFO full: the head stalls in ACCESS while four more are offered
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b0, 32'h100 + 32'(i * 4), 32'h0, 32'h0);
      check($sformatf("full cmd_ready accept%0d", i), cmd_ready, 1);
      step();
    end
    drive_cmd(1'b0, 32'h110, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full cmd_ready blocked%0d", i), cmd_ready, 0);
      check("full head in ACCESS", penable, 1);
      step();
    end
    pready = 1'b1;
    prdata = 32'hC0DE_0000;
    check("full cmd_ready during pop", cmd_ready, 0);
    check("full head paddr", paddr, 32'h100);
    step();
    pready = 1'b0;
    prdata = '0;
    check("full cmd_ready after pop", cmd_ready, 1);
    check("full rsp_valid head", rsp_valid, 1);
    check("full rsp_rdata head", rsp_rdata, 32'hC0DE_0000);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    clear_cmd();
    check("full cmd_ready refilled", cmd_ready, 0);
    for (int i = 1; i < 5; i++) serve_one(32'h100 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
    step();
    check("full drained cmd_ready", cmd_ready, 1);
    check("full drained psel", psel, 0);

    // ACCESS with pready held low
    drive_cmd(1'b0, 32'h3003_0050, 32'h0, 32'h0);
    step();
    clear_cmd();
    step();
    n = 0;
`ifdef CALIPTRA_APB_INIT_TIMEOUT_EN
    while (penable && n < 200) begin
      n++;
      step();
    end
    check("timeout ACCESS cycles", n, 16);
    check("timeout psel dropped", psel, 0);
    check("timeout rsp_valid", rsp_valid, 1);
    check("timeout rsp_err", rsp_err, 1);
    check("timeout rsp_timeout", rsp_timeout, 1);
    check("timeout rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`else
    for (int i = 0; i < 120; i++) begin
      if (psel && penable) n++;
      step();
    end
    check("no-timeout ACCESS held", n, 120);
    check("no-timeout rsp_valid", rsp_valid, 0);
    pready = 1'b1;
    prdata = 32'h0000_00AB;
    step();
    pready = 1'b0;
    check("no-timeout rsp_rdata", rsp_rdata, 32'h0000_00AB);
    check("no-timeout rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`endif
    check("post-stall idle", psel, 0);

    // Reset in the second ACCESS cycle with a second command queued
    drive_cmd(1'b1, 32'h200, 32'h1111_1111, 32'h0);
    step();
    drive_cmd(1'b1, 32'h204, 32'h2222_2222, 32'h0);
    step();
    clear_cmd();
    step();
    check("rst 2nd ACCESS penable", penable, 1);
    cptra_rst_b = 1'b0;
    step();
    cptra_rst_b = 1'b1;
    check("rst psel", psel, 0);
    check("rst penable", penable, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst cmd_ready", cmd_ready, 1);
    check("rst paddr", paddr, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (psel || rsp_valid) n++;
    end
    check("rst no further transfers", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/caliptra_apb_initiator.md
CALIPTRA_APB_INITIATOR -- requirements
Module: caliptra_apb_initiator

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command FIFO entries, power of 2, >= 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256: ACCESS-phase cycle limit, >= 2.
REQ-003 SHALL have port core_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port cptra_rst_b  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  FIFO can accept a command.
REQ-007 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  input  CALIPTRA_APB_ADDR_WIDTH  target address.
REQ-009 SHALL have port cmd_wdata  input  CALIPTRA_APB_DATA_WIDTH  write data.
REQ-010 SHALL have port cmd_user  input  CALIPTRA_APB_USER_WIDTH  PAUSER value for this command.
REQ-011 SHALL have port rsp_valid  output  1  response held.
REQ-012 SHALL have port rsp_ready  input  1  response consumed.
REQ-013 SHALL have port rsp_rdata  output  CALIPTRA_APB_DATA_WIDTH  read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err  output  1  transfer failed (pslverr or timeout).
REQ-015 SHALL have port rsp_timeout  output  1  failure caused by timeout.
REQ-016 SHALL have port psel  output  1  APB select.
REQ-017 SHALL have port penable  output  1  APB enable.
REQ-018 SHALL have port pwrite  output  1  APB direction.
REQ-019 SHALL have port paddr  output  CALIPTRA_APB_ADDR_WIDTH  APB address.
REQ-020 SHALL have port pwdata  output  CALIPTRA_APB_DATA_WIDTH  APB write data.
REQ-021 SHALL have port pauser  output  CALIPTRA_APB_USER_WIDTH  APB user.
REQ-022 SHALL have port prdata  input  CALIPTRA_APB_DATA_WIDTH  APB read data.
REQ-023 SHALL have port pready  input  1  APB ready.
REQ-024 SHALL have port pslverr  input  1  APB slave error.

Function
REQ-025 SHALL set cmd_ready = !full (registered occupancy, independent of same-cycle pop); push on cmd_valid && cmd_ready; in-order FIFO.
REQ-026 SHALL implement FSM IDLE -> SETUP when FIFO non-empty and !rsp_valid; SETUP -> ACCESS unconditionally after 1 cycle; ACCESS -> IDLE on pready (or timeout).
REQ-027 SHALL drive psel=1/penable=0 in SETUP, psel=1/penable=1 in ACCESS, both 0 in IDLE.
REQ-028 SHALL hold paddr/pwrite/pwdata/pauser from the FIFO head, stable across SETUP and all ACCESS cycles; all four 0 in IDLE.
REQ-029 SHALL, on ACCESS && pready, pop FIFO, load rsp_rdata = (read && !pslverr) ? prdata : 0, rsp_err = pslverr, rsp_timeout = 0, and set rsp_valid next cycle.
REQ-030 SHALL hold the response registers unchanged until rsp_valid && rsp_ready, then clear rsp_valid; single response slot.
REQ-031 SHALL achieve minimum latency: command accepted in cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3 when pready=1 in N+2; minimum 3 cycles per transfer.
REQ-032 SHALL treat the ACCESS cycle count as unbounded when the timeout feature is absent.

Reset
REQ-033 SHALL, when cptra_rst_b=0 at a clock edge (including mid-SETUP/ACCESS), empty the FIFO, enter IDLE, and drive every output 0 except cmd_ready=1 from the next cycle; pending response discarded.

Configuration
REQ-034 SHALL, with CALIPTRA_APB_INIT_TIMEOUT_EN defined, count ACCESS cycles and, if pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, abort: return to IDLE, pop the command, respond with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-035 SHALL, without CALIPTRA_APB_INIT_TIMEOUT_EN, omit the counter, wait indefinitely in ACCESS, tie rsp_timeout to 0, and ignore TIMEOUT_CYCLES.

Structure
REQ-036 SHALL place the command struct (write, addr, wdata, user), the FSM state enum and the response struct in package caliptra_apb_init_pkg.
REQ-037 SHALL implement the command buffer as sub-module caliptra_apb_init_fifo (sync FIFO, wrap-around pointers with extra MSB for full/empty).

Verification
REQ-038 SHALL cover: write addr 0x3003_0000, wdata 0xDEAD_BEEF, user 0xFFFF_FFFF, pready=1 -> psel high 2 cycles, penable 1 cycle, rsp_valid in N+3, rsp_err=0, rsp_rdata=0.
REQ-039 SHALL cover: read with 3 wait states, prdata=0x1234_5678 -> ACCESS 4 cycles, paddr stable, rsp_rdata=0x1234_5678.
REQ-040 SHALL cover: pready=0 held, 5 commands offered back-to-back with FIFO_DEPTH=4 -> 4 accepted, cmd_ready=0 on the 5th until a pop occurs.
REQ-041 SHALL cover: read with pslverr=1, prdata=0xFFFF_FFFF -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-042 SHALL cover: TIMEOUT_CYCLES=16, pready never -> with macro, psel drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; without macro, psel stays high for 100+ cycles.
REQ-043 SHALL cover: cptra_rst_b=0 during the 2nd ACCESS cycle with 2 queued commands -> next cycle psel=penable=rsp_valid=0, cmd_ready=1, and no further transfers issue.
